// File: rtl/hc595_stream_rx_if.sv
// Serial 74HC595-style input lines plus the decoded word/frame outputs of hc595_stream_rx.
interface hc595_stream_rx_if #(
  parameter int unsigned ERR_W = 8
);
  logic             ser_data;
  logic             ser_clock;
  logic             ser_latch;
  logic [15:0]      word_out;
  logic             word_valid;
  logic [2:0]       digit_idx;
  logic [47:0]      frame_out;
  logic             frame_valid;
  logic             err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output ser_data, ser_clock, ser_latch,
    input  word_out, word_valid, digit_idx, frame_out, frame_valid, err, err_count
  );

  modport slave (
    input  ser_data, ser_clock, ser_latch,
    output word_out, word_valid, digit_idx, frame_out, frame_valid, err, err_count
  );
endinterface

// File: rtl/hc595_stream_rx.sv
// Receives a 16-bit {mask, seg} stream from an HC595-style serial bus and assembles
// six in-order digits into a 48-bit display frame, flagging framing and mask errors.
module hc595_stream_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_W       = 8
) (
  input logic               s_clk,
  input logic               s_reset_n,
  hc595_stream_rx_if.slave  bus
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned FRAME_W = 48;
  localparam int unsigned DIGITS  = 6;

  typedef enum logic [0:0] {ST_IDLE, ST_COLLECT} state_e;

  // synchronizers and edge history
  logic [SYNC_STAGES-1:0] data_sync_q, clk_sync_q, lat_sync_q;
  logic                   clk_prev_q, lat_prev_q;
  logic                   clk_rise_c, lat_rise_c;

  // stage A: registered edge events
  logic                   clk_edge_q, lat_edge_q, bit_q;

  // stage B: shift register, bit count and commit decision
  logic [WORD_W-1:0]      shift_q, shift_d, shift_post_c;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_post_c;
  logic                   commit_q, commit_d, bad_q, bad_d;
  logic [WORD_W-1:0]      pend_q;

  // stage C: decode, frame tracker and outputs
  state_e                 state_q, state_d;
  logic [2:0]             exp_q, exp_d, exp_cur_c;
  logic [WORD_W-1:0]      word_out_q, word_out_d;
  logic                   word_valid_q, word_valid_d;
  logic [2:0]             digit_q, digit_d;
  logic [FRAME_W-1:0]     frame_buf_q, frame_buf_d;
  logic [FRAME_W-1:0]     frame_out_q, frame_out_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   err_q, err_d;
  logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;
  logic [7:0]             inv_c;
  logic                   legal_c;
  logic [2:0]             pos_c;

  assign clk_rise_c = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  assign lat_rise_c = lat_sync_q[SYNC_STAGES-1] & ~lat_prev_q;

  // front end: synchronize lines, detect rising edges, register the events
  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      data_sync_q <= '0;
      clk_sync_q  <= '0;
      lat_sync_q  <= '0;
      clk_prev_q  <= 1'b0;
      lat_prev_q  <= 1'b0;
      clk_edge_q  <= 1'b0;
      lat_edge_q  <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ser_data};
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ser_clock};
      lat_sync_q  <= {lat_sync_q[SYNC_STAGES-2:0], bus.ser_latch};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      lat_prev_q  <= lat_sync_q[SYNC_STAGES-1];
      clk_edge_q  <= clk_rise_c;
      lat_edge_q  <= lat_rise_c;
      bit_q       <= data_sync_q[SYNC_STAGES-1];
    end
  end

  // shift applies before a coincident latch, so the latch sees post-shift state
  always_comb begin
    shift_post_c = shift_q;
    cnt_post_c   = cnt_q;
    if (clk_edge_q) begin
      shift_post_c = {shift_q[WORD_W-2:0], bit_q};
      cnt_post_c   = (cnt_q == '1) ? cnt_q : CNT_W'(cnt_q + CNT_W'(1));
    end
    shift_d  = shift_post_c;
    cnt_d    = lat_edge_q ? '0 : cnt_post_c;
    commit_d = lat_edge_q && (cnt_post_c == CNT_W'(WORD_W));
    bad_d    = lat_edge_q && (cnt_post_c != CNT_W'(WORD_W));
  end

  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      bad_q    <= 1'b0;
      pend_q   <= '0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      bad_q    <= bad_d;
      pend_q   <= shift_post_c;
    end
  end

  // mask is legal when exactly one zero bit sits in positions 0..5
  always_comb begin
    inv_c   = ~pend_q[15:8];
    legal_c = (inv_c != 8'h00) && ((inv_c & 8'(inv_c - 8'd1)) == 8'h00) && (inv_c[7:6] == 2'b00);
    pos_c   = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (inv_c[i]) pos_c = 3'(i);
    end
  end

  assign exp_cur_c = (state_q == ST_IDLE) ? 3'd0 : exp_q;

  // frame tracker next state and output staging
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    word_out_d    = word_out_q;
    word_valid_d  = 1'b0;
    digit_d       = digit_q;
    frame_buf_d   = frame_buf_q;
    frame_out_d   = frame_out_q;
    frame_valid_d = 1'b0;
    err_d         = 1'b0;
    err_cnt_d     = err_cnt_q;

    if (bad_q) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
      exp_d   = 3'd0;
    end else if (commit_q) begin
      word_out_d   = pend_q;
      word_valid_d = 1'b1;
      if (!legal_c) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
        exp_d   = 3'd0;
      end else begin
        digit_d = pos_c;
        for (int k = 0; k < DIGITS; k++) begin
          if (pos_c == 3'(k)) frame_buf_d[8*k +: 8] = pend_q[7:0];
        end
        if (pos_c == exp_cur_c) begin
          if (pos_c == 3'(DIGITS - 1)) begin
            frame_out_d   = {pend_q[7:0], frame_buf_q[39:0]};
            frame_valid_d = 1'b1;
            state_d       = ST_IDLE;
            exp_d         = 3'd0;
          end else begin
            state_d = ST_COLLECT;
            exp_d   = 3'(pos_c + 3'd1);
          end
        end else begin
          err_d = 1'b1;
          if (pos_c == 3'd0) begin
            state_d = ST_COLLECT;
            exp_d   = 3'd1;
          end else begin
            state_d = ST_IDLE;
            exp_d   = 3'd0;
          end
        end
      end
    end

    if (err_d && (err_cnt_q != '1)) err_cnt_d = ERR_W'(err_cnt_q + ERR_W'(1));
  end

  always_ff @(posedge s_clk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      state_q       <= ST_IDLE;
      exp_q         <= 3'd0;
      word_out_q    <= '0;
      word_valid_q  <= 1'b0;
      digit_q       <= 3'd0;
      frame_buf_q   <= '0;
      frame_out_q   <= '0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      word_out_q    <= word_out_d;
      word_valid_q  <= word_valid_d;
      digit_q       <= digit_d;
      frame_buf_q   <= frame_buf_d;
      frame_out_q   <= frame_out_d;
      frame_valid_q <= frame_valid_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.word_out    = word_out_q;
  assign bus.word_valid  = word_valid_q;
  assign bus.digit_idx   = digit_q;
  assign bus.frame_out   = frame_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.err         = err_q;
  assign bus.err_count   = err_cnt_q;

endmodule

// File: tb/tb_hc595_stream_rx.sv
// Bench for hc595_stream_rx: directed scenarios plus random words checked against a
// transaction-level model of word commit, digit decode and frame assembly.
module tb_hc595_stream_rx;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned ERR_W       = 8;
  localparam int          OBS_CYCLES  = 16;

  logic s_clk     = 1'b0;
  logic s_reset_n = 1'b0;
  always #5 s_clk = ~s_clk;

  hc595_stream_rx_if #(.ERR_W(ERR_W)) bus();

  hc595_stream_rx #(.SYNC_STAGES(SYNC_STAGES), .ERR_W(ERR_W)) dut (
    .s_clk     (s_clk),
    .s_reset_n (s_reset_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // reference model: expected index, digit slots, last published values
  int          m_exp;
  logic [7:0]  m_buf [6];
  logic [47:0] m_frame;
  logic [15:0] m_word;
  logic [2:0]  m_digit;
  int          m_errcnt;

  function automatic void model_reset();
    m_exp    = 0;
    for (int i = 0; i < 6; i++) m_buf[i] = 8'h00;
    m_frame  = '0;
    m_word   = '0;
    m_digit  = '0;
    m_errcnt = 0;
  endfunction

  function automatic void model_step(input logic [15:0] w, input int nbits,
                                     output int e_wv, output int e_fv, output int e_err);
    int         cnt;
    int         p;
    logic [7:0] zeros;
    e_wv = 0; e_fv = 0; e_err = 0;
    cnt = (nbits > 31) ? 31 : nbits;
    if (cnt != 16) begin
      e_err = 1;
      m_exp = 0;
    end else begin
      e_wv   = 1;
      m_word = w;
      zeros  = ~w[15:8];
      if ($countones(zeros) == 1 && zeros[7:6] == 2'b00) begin
        p        = $clog2(zeros);
        m_digit  = 3'(p);
        m_buf[p] = w[7:0];
        if (p == m_exp) begin
          if (p == 5) begin
            m_frame = {m_buf[5], m_buf[4], m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            e_fv    = 1;
            m_exp   = 0;
          end else begin
            m_exp = p + 1;
          end
        end else begin
          e_err = 1;
          m_exp = (p == 0) ? 1 : 0;
        end
      end else begin
        e_err = 1;
        m_exp = 0;
      end
    end
    if (e_err != 0 && m_errcnt < 255) m_errcnt++;
  endfunction

  function automatic logic [15:0] mk(input int p, input logic [7:0] seg);
    logic [7:0] one;
    one = 8'h01;
    return {~(8'(one << p)), seg};
  endfunction

  task automatic send_bits(input logic [31:0] v, input int n, input bit hold_last);
    for (int i = n - 1; i >= 0; i--) begin
      bus.ser_data = v[i];
      repeat (3) @(negedge s_clk);
      if (i == 0 && hold_last) return;
      bus.ser_clock = 1'b1;
      repeat (4) @(negedge s_clk);
      bus.ser_clock = 1'b0;
      repeat (3) @(negedge s_clk);
    end
  endtask

  // shift a word, latch it, and compare every pulse and held output with the model
  task automatic do_word(input string tag, input logic [31:0] v, input int n, input bit same_edge);
    int          e_wv, e_fv, e_err;
    int          wv_n, fv_n, err_n, wv_at;
    logic [15:0] wv_word;
    logic [47:0] fv_frame;
    model_step(v[15:0], n, e_wv, e_fv, e_err);
    send_bits(v, n, same_edge);
    wv_n = 0; fv_n = 0; err_n = 0; wv_at = -1; wv_word = '0; fv_frame = '0;
    @(negedge s_clk);
    bus.ser_latch = 1'b1;
    if (same_edge) bus.ser_clock = 1'b1;
    for (int c = 0; c < OBS_CYCLES; c++) begin
      @(negedge s_clk);
      if (bus.word_valid) begin
        wv_n++;
        if (wv_at < 0) wv_at = c;
        wv_word = bus.word_out;
      end
      if (bus.frame_valid) begin
        fv_n++;
        fv_frame = bus.frame_out;
      end
      if (bus.err) err_n++;
      if (c == 4) begin
        bus.ser_latch = 1'b0;
        bus.ser_clock = 1'b0;
      end
    end
    check($sformatf("%s.wv_pulses", tag), 64'(wv_n), 64'(e_wv));
    check($sformatf("%s.fv_pulses", tag), 64'(fv_n), 64'(e_fv));
    check($sformatf("%s.err_pulses", tag), 64'(err_n), 64'(e_err));
    if (e_wv != 0) begin
      check($sformatf("%s.latency", tag), 64'(wv_at), 64'(SYNC_STAGES + 2));
      check($sformatf("%s.wv_word", tag), 64'(wv_word), 64'(m_word));
    end
    if (e_fv != 0) check($sformatf("%s.fv_frame", tag), 64'(fv_frame), 64'(m_frame));
    check($sformatf("%s.word_out", tag), 64'(bus.word_out), 64'(m_word));
    check($sformatf("%s.digit_idx", tag), 64'(bus.digit_idx), 64'(m_digit));
    check($sformatf("%s.err_count", tag), 64'(bus.err_count), 64'(m_errcnt));
    check($sformatf("%s.frame_out", tag), 64'(bus.frame_out), 64'(m_frame));
  endtask

  task automatic do_reset(input string tag);
    @(negedge s_clk);
    s_reset_n     = 1'b0;
    bus.ser_data  = 1'b0;
    bus.ser_clock = 1'b0;
    bus.ser_latch = 1'b0;
    repeat (3) @(negedge s_clk);
    check($sformatf("%s.rst_word_out", tag), 64'(bus.word_out), 64'h0);
    check($sformatf("%s.rst_word_valid", tag), 64'(bus.word_valid), 64'h0);
    check($sformatf("%s.rst_digit_idx", tag), 64'(bus.digit_idx), 64'h0);
    check($sformatf("%s.rst_frame_out", tag), 64'(bus.frame_out), 64'h0);
    check($sformatf("%s.rst_frame_valid", tag), 64'(bus.frame_valid), 64'h0);
    check($sformatf("%s.rst_err", tag), 64'(bus.err), 64'h0);
    check($sformatf("%s.rst_err_count", tag), 64'(bus.err_count), 64'h0);
    s_reset_n = 1'b1;
    @(negedge s_clk);
    check($sformatf("%s.post_rst_pulses", tag),
          64'({bus.word_valid, bus.frame_valid, bus.err}), 64'h0);
    model_reset();
  endtask

  initial begin
    int          kind, p, n;
    logic [31:0] v;
    bus.ser_data  = 1'b0;
    bus.ser_clock = 1'b0;
    bus.ser_latch = 1'b0;
    model_reset();

    do_reset("init");

    do_word("first", 32'h0000FE3F, 16, 1'b0);

    for (int d = 0; d < 6; d++) do_word($sformatf("frame.d%0d", d), 32'(mk(d, 8'(8'h11 * (d + 1)))), 16, 1'b0);

    do_word("short15", 32'h00005A5A, 15, 1'b0);

    do_word("badmask", 32'h0000FC00, 16, 1'b0);
    do_word("ooo.fd", 32'(mk(1, 8'h77)), 16, 1'b0);
    do_word("ooo.fe", 32'(mk(0, 8'h88)), 16, 1'b0);
    do_word("ooo.fd2", 32'(mk(1, 8'h99)), 16, 1'b0);

    for (int d = 0; d < 3; d++) do_word($sformatf("pre.d%0d", d), 32'(mk(d, 8'(8'hA0 + d))), 16, 1'b0);
    do_reset("midframe");
    for (int d = 0; d < 6; d++) do_word($sformatf("post.d%0d", d), 32'(mk(d, 8'(8'hC0 + d))), 16, 1'b0);

    send_bits(32'h000000A5, 8, 1'b0);
    do_reset("midword");

    do_word("same_edge", 32'(mk(0, 8'h3C)), 16, 1'b1);
    do_word("restart0", 32'(mk(0, 8'h42)), 16, 1'b0);

    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 4));
      n    = 16;
      case (kind)
        0, 1:    v = 32'(mk(m_exp, 8'($urandom)));
        2: begin
          p = int'($urandom_range(0, 5));
          v = 32'(mk(p, 8'($urandom)));
        end
        3:       v = 32'($urandom & 32'h0000FFFF);
        default: begin
          v = $urandom;
          n = int'($urandom_range(12, 20));
        end
      endcase
      do_word($sformatf("rnd%0d", t), v, n, ($urandom_range(0, 5) == 0) && (n == 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
